// File: rtl/rtc_status_pkg.sv
// Shared types and constants for the RTC status-modify write path.
// Flag indices name the user flags in their default bit positions.
package rtc_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_COUNT,
    ST_PRESENT,
    ST_DONE
  } state_e;

  localparam int CTRL_MODE_DEF = 3;

  localparam int IDX_CRONO = 0;
  localparam int IDX_FH    = 1;
  localparam int IDX_AA    = 2;

endpackage

// File: rtl/slot_counter.sv
// Counts qualified bus-slot ticks up to SLOT_CNT; saturates, never wraps.
// term is combinational: high on the tick that brings the count to SLOT_CNT.
module slot_counter #(
  parameter int SLOT_CNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  input  logic tick,
  output logic term
);

  localparam int CW = $clog2(SLOT_CNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    term  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en && tick && (cnt_q != CW'(SLOT_CNT))) begin
      cnt_d = cnt_q + 1'b1;
      term  = (cnt_q == CW'(SLOT_CNT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/status_mod_gen.sv
// Status-register write generator: snapshot flags, apply inhibit/mask, wait SLOT_CNT
// qualified ticks, then hold a write request until the bus writer acks it.
module status_mod_gen
  import rtc_status_pkg::*;
#(
  parameter int                   N_FLAGS        = 3,
  parameter int                   DATA_W         = 8,
  parameter int                   FLAG_LSB       = 3,
  parameter logic [N_FLAGS-1:0]   OUT_MASK       = 3'b011,
  parameter int                   INHIB_SRC      = IDX_AA,
  parameter logic [N_FLAGS-1:0]   INHIB_MASK     = 3'b001,
  parameter int                   SLOT_CNT       = 2,
  parameter int                   CTRL_W         = 2,
  parameter int                   CTRL_MODE      = CTRL_MODE_DEF,
  parameter bit                   SKIP_UNCHANGED = 1'b1
) (
  input  logic                reloj,
  input  logic                resetM,
  input  logic [CTRL_W-1:0]   Control,
  input  logic [N_FLAGS-1:0]  flags_in,
  input  logic                enable_cont_16,
  input  logic                enable_cont_MS,
  input  logic                wr_ack,
  output logic [DATA_W-1:0]   mod_s,
  output logic [N_FLAGS-1:0]  flag_en,
  output logic                wr_req,
  output logic                busy
);

  if (FLAG_LSB + N_FLAGS > DATA_W) begin : g_bad_width
    $error("status_mod_gen: flags do not fit in DATA_W");
  end
  if (SLOT_CNT < 1) begin : g_bad_slot
    $error("status_mod_gen: SLOT_CNT must be at least 1");
  end

  state_e               state_q, state_d;
  logic [N_FLAGS-1:0]   eff_q, eff_d;
  logic [N_FLAGS-1:0]   last_q, last_d;
  logic [N_FLAGS-1:0]   flag_en_q, flag_en_d;
  logic [DATA_W-1:0]    mod_s_q, mod_s_d;
  logic                 wr_req_q, wr_req_d;
  logic                 busy_q, busy_d;
  logic [N_FLAGS-1:0]   snap_eff;
  logic                 in_mode;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 slot_term;

  assign in_mode  = (Control == CTRL_W'(CTRL_MODE));
  assign snap_eff = flags_in & ~(flags_in[INHIB_SRC] ? INHIB_MASK : '0) & OUT_MASK;

  slot_counter #(
    .SLOT_CNT (SLOT_CNT)
  ) u_slot_counter (
    .clk    (reloj),
    .rst_n  (resetM),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .tick   (enable_cont_16 && enable_cont_MS),
    .term   (slot_term)
  );

  always_comb begin
    state_d = state_q;
    eff_d   = eff_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_mode) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        cnt_clr = 1'b1;
        eff_d   = snap_eff;
        if (!in_mode) begin
          state_d = ST_IDLE;
        end else if (SKIP_UNCHANGED && (snap_eff == last_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        cnt_en = 1'b1;
        if (!in_mode) begin
          state_d = ST_IDLE;
        end else if (slot_term) begin
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // An ack beats a simultaneous mode exit: the write is committed.
        if (wr_ack) begin
          last_d  = eff_q;
          state_d = ST_DONE;
        end else if (!in_mode) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (!in_mode) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    busy_d    = (state_d == ST_SNAP) || (state_d == ST_COUNT) || (state_d == ST_PRESENT);
    wr_req_d  = (state_d == ST_PRESENT);
    mod_s_d   = wr_req_d ? (DATA_W'(eff_d) << FLAG_LSB) : '0;
    flag_en_d = wr_req_d ? eff_d : '0;
  end

  always_ff @(posedge reloj) begin
    if (!resetM) begin
      state_q   <= ST_IDLE;
      eff_q     <= '0;
      last_q    <= '0;
      mod_s_q   <= '0;
      flag_en_q <= '0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      eff_q     <= eff_d;
      last_q    <= last_d;
      mod_s_q   <= mod_s_d;
      flag_en_q <= flag_en_d;
      wr_req_q  <= wr_req_d;
      busy_q    <= busy_d;
    end
  end

  assign mod_s   = mod_s_q;
  assign flag_en = flag_en_q;
  assign wr_req  = wr_req_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_status_mod_gen.sv
// Randomized scoreboard bench: a skipping instance (a) and a non-skipping instance (b)
// share stimulus; monitors compare each presented write against the reference queue.
module tb_status_mod_gen;

  localparam int SLOT = 2;

  typedef struct {
    logic [7:0] mod;
    logic [2:0] en;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ctrl;
  logic [2:0] flags;
  logic       en16, enms, ack;

  logic [7:0] mod_s_a, mod_s_b;
  logic [2:0] flag_en_a, flag_en_b;
  logic       wr_req_a, wr_req_b, busy_a, busy_b;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  logic [2:0] last_model = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  status_mod_gen u_dut_a (
    .reloj(clk), .resetM(rst_n), .Control(ctrl), .flags_in(flags),
    .enable_cont_16(en16), .enable_cont_MS(enms), .wr_ack(ack),
    .mod_s(mod_s_a), .flag_en(flag_en_a), .wr_req(wr_req_a), .busy(busy_a)
  );

  status_mod_gen #(.SKIP_UNCHANGED(1'b0)) u_dut_b (
    .reloj(clk), .resetM(rst_n), .Control(ctrl), .flags_in(flags),
    .enable_cont_16(en16), .enable_cont_MS(enms), .wr_ack(ack),
    .mod_s(mod_s_b), .flag_en(flag_en_b), .wr_req(wr_req_b), .busy(busy_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference rule: A_A inhibits act_crono, only F_H and act_crono are written.
  function automatic logic [2:0] eff_of(input logic [2:0] f);
    logic [2:0] e;
    e = f;
    if (f[2]) e[0] = 1'b0;
    e[2] = 1'b0;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive(input logic [1:0] c, input logic [2:0] f, input logic e16,
                       input logic ems, input logic a, input logic r);
    @(negedge clk);
    ctrl = c; flags = f; en16 = e16; enms = ems; ack = a; rst_n = r;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal ack, 1 abort in COUNT, 2 abort in PRESENT, 3 ack with mode drop, 4 reset in PRESENT
  task automatic run_txn(input logic [2:0] f, input int mode);
    logic [2:0] eff;
    logic       skip, e16, ems;
    int         q, n;
    exp_t       e;
    eff  = eff_of(f);
    skip = (eff == last_model);
    drive(2'd3, f, rb(), rb(), 1'b0, 1'b1);
    chk("busy_snap", busy_a, 1);
    drive(2'd3, f, rb(), rb(), rb(), 1'b1);
    chk("busy_after_snap", busy_a, int'(!skip));
    q = 0;
    n = 0;
    while (q < SLOT) begin
      if (mode == 1 && q == 1) begin
        drive(2'd0, 3'($urandom), rb(), rb(), 1'b0, 1'b1);
        chk("abort_count_busy_a", busy_a, 0);
        chk("abort_count_busy_b", busy_b, 0);
        drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        return;
      end
      e16 = (n > 12) ? 1'b1 : rb();
      ems = (n > 12) ? 1'b1 : rb();
      drive(2'd3, 3'($urandom), e16, ems, rb(), 1'b1);
      if (e16 && ems) q++;
      n++;
    end
    e.mod = 8'(eff) * 8'd8;
    e.en  = eff;
    e.cyc = cyc;
    qb.push_back(e);
    if (!skip) qa.push_back(e);
    repeat ($urandom_range(0, 3)) drive(2'd3, 3'($urandom), rb(), rb(), 1'b0, 1'b1);
    case (mode)
      2: begin
        drive(2'd0, 3'd0, rb(), rb(), 1'b0, 1'b1);
        chk("abort_present_req_b", wr_req_b, 0);
      end
      4: begin
        drive(2'd0, 3'd0, rb(), rb(), 1'b0, 1'b0);
        last_model = 3'b000;
        chk("rst_req_a", wr_req_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_req_b", wr_req_b, 0);
        chk("rst_out_b", {mod_s_b, flag_en_b}, 0);
      end
      3: begin
        drive(2'd0, 3'd0, rb(), rb(), 1'b1, 1'b1);
        last_model = eff;
        chk("ackdrop_busy_b", busy_b, 0);
      end
      default: begin
        drive(2'd3, 3'($urandom), rb(), rb(), 1'b1, 1'b1);
        last_model = eff;
        chk("ack_req_low_b", wr_req_b, 0);
        drive(2'd3, 3'($urandom), rb(), rb(), 1'b0, 1'b1);
        chk("done_busy_a", busy_a, 0);
        chk("done_busy_b", busy_b, 0);
      end
    endcase
    drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic prev_a = 1'b0, prev_b = 1'b0;
  exp_t cur_a, cur_b;

  always @(negedge clk) begin
    if (mon_on) begin
      if (wr_req_a && !prev_a) begin
        if (qa.size() == 0) chk("a_unexpected_req", 1, 0);
        else begin
          cur_a = qa.pop_front();
          chk("a_req_cycle", cyc, cur_a.cyc);
        end
      end
      if (wr_req_a) begin
        chk("a_mod_s", mod_s_a, cur_a.mod);
        chk("a_flag_en", flag_en_a, cur_a.en);
      end else begin
        chk("a_idle_out", {mod_s_a, flag_en_a}, 0);
      end
      prev_a = wr_req_a;

      if (wr_req_b && !prev_b) begin
        if (qb.size() == 0) chk("b_unexpected_req", 1, 0);
        else begin
          cur_b = qb.pop_front();
          chk("b_req_cycle", cyc, cur_b.cyc);
        end
      end
      if (wr_req_b) begin
        chk("b_mod_s", mod_s_b, cur_b.mod);
        chk("b_flag_en", flag_en_b, cur_b.en);
      end else begin
        chk("b_idle_out", {mod_s_b, flag_en_b}, 0);
      end
      prev_b = wr_req_b;
    end
  end

  initial begin
    int m, r;
    rst_n = 1'b0; ctrl = 2'd0; flags = 3'd0; en16 = 1'b0; enms = 1'b0; ack = 1'b0;
    repeat (3) drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_mod_s", mod_s_a, 0);
    chk("reset_flag_en", flag_en_a, 0);
    chk("reset_wr_req", wr_req_a, 0);
    chk("reset_busy", busy_a, 0);
    mon_on = 1'b1;
    drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    run_txn(3'b001, 0);
    run_txn(3'b111, 0);
    run_txn(3'b011, 0);
    run_txn(3'b011, 0);
    run_txn(3'b001, 0);
    run_txn(3'b001, 0);
    run_txn(3'b011, 1);
    run_txn(3'b011, 0);
    run_txn(3'b111, 2);
    run_txn(3'b111, 3);
    run_txn(3'b111, 0);
    run_txn(3'b001, 4);
    run_txn(3'b001, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      m = (r <= 5) ? 0 : r - 5;
      run_txn(3'($urandom), m);
    end

    repeat (4) drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a_pending_writes", qa.size(), 0);
    chk("b_pending_writes", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
